// File: rtl/adc_sample_packer.sv
`default_nettype none
// ============================================================================
// Module   : adc_sample_packer
// Purpose  : ADC capture front end. Decimates the incoming sample stream,
//            counts accepted samples and packs SPW = (WORD_W-2)/SAMPLE_W
//            samples plus out-of-range / trigger status into one FIFO word.
//            Owns the capture stop decision (count reached or FIFO overflow).
// Ports    : adc_sampleclk      - sample clock, rising edge
//            reset_i            - asynchronous active-high reset
//            capture_go_i       - level: 1 arm/run, 0 abort / return to IDLE
//            max_samples_i      - accepted-sample limit (latched at start)
//            decimate_i         - keep 1 of (decimate_i+1) (latched at start)
//            adc_data_i         - ADC sample
//            adc_or_i           - out-of-range flag for this sample
//            adc_trig_status_i  - trigger status for this sample
//            fifo_full_i        - sample FIFO full
//            fifo_din_o         - packed word
//            fifo_wr_en_o       - one-cycle write strobe
//            capture_stop_o     - capture finished (DONE)
//            samples_o          - accepted-sample count
//            overflow_o         - sticky: word dropped because FIFO was full
// Config   : ADC_PACKER_FLUSH_EN - when defined, a partial word is written
//            when the sample count is reached; otherwise it is discarded.
// Revision : 1.0 - initial release
// ============================================================================
module adc_sample_packer #(
    parameter int SAMPLE_W = 10,
    parameter int WORD_W   = 32,
    parameter int CNT_W    = 32,
    parameter int DEC_W    = 16
) (
    input  logic                adc_sampleclk,
    input  logic                reset_i,
    input  logic                capture_go_i,
    input  logic [CNT_W-1:0]    max_samples_i,
    input  logic [DEC_W-1:0]    decimate_i,
    input  logic [SAMPLE_W-1:0] adc_data_i,
    input  logic                adc_or_i,
    input  logic                adc_trig_status_i,
    input  logic                fifo_full_i,
    output logic [WORD_W-1:0]   fifo_din_o,
    output logic                fifo_wr_en_o,
    output logic                capture_stop_o,
    output logic [CNT_W-1:0]    samples_o,
    output logic                overflow_o
);

    localparam int SPW    = (WORD_W - 2) / SAMPLE_W;
    localparam int LANE_W = (SPW > 1) ? $clog2(SPW) : 1;
    localparam int PACK_W = SPW * SAMPLE_W;

`ifdef ADC_PACKER_FLUSH_EN
    localparam logic FLUSH_EN = 1'b1;
`else
    localparam logic FLUSH_EN = 1'b0;
`endif

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  max_q, max_d;
    logic [DEC_W-1:0]  dec_q, dec_d;
    logic [DEC_W-1:0]  dec_cnt_q, dec_cnt_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [PACK_W-1:0] word_q, word_d;
    logic              or_acc_q, or_acc_d;
    logic [CNT_W-1:0]  samples_q, samples_d;
    logic              overflow_q, overflow_d;
    logic [WORD_W-1:0] fifo_din_q, fifo_din_d;
    logic              fifo_wr_en_q, fifo_wr_en_d;

    logic              start;
    logic              accept;
    logic              last_lane;
    logic              count_hit;
    logic              emit;
    logic              drop;
    logic [CNT_W-1:0]  samples_inc;
    logic [PACK_W-1:0] merged_word;
    logic [WORD_W-1:0] packed_word;

    // ------------------------------------------------------------------
    // Sample acceptance and word assembly
    // ------------------------------------------------------------------
    always_comb begin
        start       = (state_q == S_IDLE) && capture_go_i;
        // Aborting (capture_go_i low) takes priority: no sample is taken
        // in the cycle the capture is dropped.
        accept      = (state_q == S_CAPTURE) && capture_go_i && (dec_cnt_q == '0);
        samples_inc = samples_q + CNT_W'(1);
        last_lane   = (lane_q == LANE_W'(SPW - 1));
        count_hit   = (samples_inc == max_q);
        // A word leaves either when its last lane fills or, with flushing,
        // when the final sample lands in a partially filled word.
        emit        = accept && (last_lane || (count_hit && FLUSH_EN));
        drop        = emit && fifo_full_i;

        merged_word = word_q;
        for (int l = 0; l < SPW; l++) begin
            if (lane_q == LANE_W'(l)) begin
                merged_word[l*SAMPLE_W +: SAMPLE_W] = adc_data_i;
            end
        end

        // Unused bits between the lanes and the status bits stay zero.
        packed_word             = '0;
        packed_word[PACK_W-1:0] = merged_word;
        packed_word[WORD_W-1]   = or_acc_q | adc_or_i;
        packed_word[WORD_W-2]   = adc_trig_status_i;
    end

    always_comb begin
        max_d        = max_q;
        dec_d        = dec_q;
        dec_cnt_d    = dec_cnt_q;
        lane_d       = lane_q;
        word_d       = word_q;
        or_acc_d     = or_acc_q;
        samples_d    = samples_q;
        overflow_d   = overflow_q;
        fifo_din_d   = fifo_din_q;
        fifo_wr_en_d = 1'b0;

        if (start) begin
            max_d      = max_samples_i;
            dec_d      = decimate_i;
            dec_cnt_d  = '0;
            lane_d     = '0;
            word_d     = '0;
            or_acc_d   = 1'b0;
            samples_d  = '0;
            overflow_d = 1'b0;
        end else if ((state_q == S_CAPTURE) && capture_go_i) begin
            dec_cnt_d = (dec_cnt_q == dec_q) ? '0 : dec_cnt_q + DEC_W'(1);
            if (accept) begin
                samples_d = samples_inc;
                if (emit) begin
                    lane_d   = '0;
                    word_d   = '0;
                    or_acc_d = 1'b0;
                    if (fifo_full_i) begin
                        overflow_d = 1'b1;
                    end else begin
                        fifo_din_d   = packed_word;
                        fifo_wr_en_d = 1'b1;
                    end
                end else begin
                    lane_d   = lane_q + LANE_W'(1);
                    word_d   = merged_word;
                    or_acc_d = or_acc_q | adc_or_i;
                end
            end
        end
    end

    always_ff @(posedge adc_sampleclk or posedge reset_i) begin
        if (reset_i) begin
            max_q        <= '0;
            dec_q        <= '0;
            dec_cnt_q    <= '0;
            lane_q       <= '0;
            word_q       <= '0;
            or_acc_q     <= 1'b0;
            samples_q    <= '0;
            overflow_q   <= 1'b0;
            fifo_din_q   <= '0;
            fifo_wr_en_q <= 1'b0;
        end else begin
            max_q        <= max_d;
            dec_q        <= dec_d;
            dec_cnt_q    <= dec_cnt_d;
            lane_q       <= lane_d;
            word_q       <= word_d;
            or_acc_q     <= or_acc_d;
            samples_q    <= samples_d;
            overflow_q   <= overflow_d;
            fifo_din_q   <= fifo_din_d;
            fifo_wr_en_q <= fifo_wr_en_d;
        end
    end

    // ------------------------------------------------------------------
    // Capture FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge adc_sampleclk or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (capture_go_i) begin
                    state_d = (max_samples_i == '0) ? S_DONE : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (!capture_go_i) begin
                    state_d = S_IDLE;
                end else if (drop || (accept && count_hit)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!capture_go_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        capture_stop_o = (state_q == S_DONE);
    end

    assign fifo_din_o   = fifo_din_q;
    assign fifo_wr_en_o = fifo_wr_en_q;
    assign samples_o    = samples_q;
    assign overflow_o   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_sample_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_sample_packer
// Purpose  : Self-checking bench for adc_sample_packer. Each capture run is
//            described by per-cycle stimulus arrays; a sample-level model
//            derives the expected per-cycle outputs, and one compare process
//            checks the DUT against them every cycle. Directed runs pin the
//            model with hand-computed words; randomized runs follow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_sample_packer;

    localparam int SW   = 10;
    localparam int WW   = 32;
    localparam int SPW  = (WW - 2) / SW;
    localparam int MAXC = 64;

`ifdef ADC_PACKER_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          go;
    logic [31:0]   max_in;
    logic [15:0]   dec_in;
    logic [SW-1:0] data_in;
    logic          or_in;
    logic          trig_in;
    logic          full_in;
    logic [WW-1:0] fifo_din;
    logic          fifo_wr_en;
    logic          capture_stop;
    logic [31:0]   samples;
    logic          overflow;

    adc_sample_packer dut (
        .adc_sampleclk     (clk),
        .reset_i           (rst),
        .capture_go_i      (go),
        .max_samples_i     (max_in),
        .decimate_i        (dec_in),
        .adc_data_i        (data_in),
        .adc_or_i          (or_in),
        .adc_trig_status_i (trig_in),
        .fifo_full_i       (full_in),
        .fifo_din_o        (fifo_din),
        .fifo_wr_en_o      (fifo_wr_en),
        .capture_stop_o    (capture_stop),
        .samples_o         (samples),
        .overflow_o        (overflow)
    );

    always #5 clk = ~clk;

    // Stimulus for one run
    logic          go_a   [MAXC];
    logic [SW-1:0] data_a [MAXC];
    logic          or_a   [MAXC];
    logic          trig_a [MAXC];
    logic          full_a [MAXC];
    int            max_r;
    int            dec_r;

    // Expected per-cycle outputs
    logic          ewr   [MAXC];
    logic [WW-1:0] edin  [MAXC];
    logic          estop [MAXC];
    int            esamp [MAXC];
    logic          eovf  [MAXC];
    logic [WW-1:0] exp_words[$];

    int prev_samp = 0;
    logic prev_ovf = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int cur_t    = 0;
    bit run_active = 1'b0;

    task automatic chk(input string name, input int t, input logic [63:0] act,
                       input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, t, act, req);
        end
    endtask

    task automatic clear_stim();
        for (int t = 0; t < MAXC; t++) begin
            go_a[t]   = 1'b0;
            data_a[t] = '0;
            or_a[t]   = 1'b0;
            trig_a[t] = 1'b0;
            full_a[t] = 1'b0;
        end
    endtask

    // go high on cycles 0..n-1, ramp data (value = cycle index)
    task automatic ramp_stim(input int n, input int mx, input int dc);
        clear_stim();
        max_r = mx;
        dec_r = dc;
        for (int t = 0; t < n; t++) begin
            go_a[t]   = 1'b1;
            data_a[t] = SW'(t);
        end
    endtask

    // Sample-level model. Cycle 0 is the first cycle with go=1 (state IDLE);
    // cycle t>=1 is capture cycle t-1. Inputs of cycle t act at the edge
    // ending it, so their effect is visible in cycle t+1.
    task automatic build_expected(input int n);
        int   accepts[$];
        int   lane_vals[$];
        int   n_go, done_t, ovf_t, cnt;
        logic ors;
        logic [WW-1:0] w;
        exp_words.delete();
        go_a[n]   = 1'b0;
        go_a[n+1] = 1'b0;
        for (int t = 0; t <= n + 1; t++) begin
            ewr[t] = 1'b0; edin[t] = '0; estop[t] = 1'b0; esamp[t] = 0; eovf[t] = 1'b0;
        end
        n_go = n;
        for (int t = 1; t <= n; t++) begin
            if (!go_a[t]) begin
                n_go = t;
                break;
            end
        end
        cnt = 0; done_t = -1; ovf_t = -1; ors = 1'b0;
        if (max_r == 0) begin
            done_t = 1;
        end else begin
            for (int t = 1; t < n_go; t++) begin
                if (((t - 1) % (dec_r + 1)) == 0) begin
                    accepts.push_back(t);
                    lane_vals.push_back(int'(data_a[t]));
                    ors = ors | or_a[t];
                    cnt++;
                    if (lane_vals.size() == SPW || (cnt == max_r && FLUSH)) begin
                        w = '0;
                        foreach (lane_vals[i]) w = w | (WW'(lane_vals[i]) << (i * SW));
                        w[WW-1] = ors;
                        w[WW-2] = trig_a[t];
                        lane_vals.delete();
                        ors = 1'b0;
                        if (full_a[t]) begin
                            ovf_t  = t + 1;
                            done_t = t + 1;
                            break;
                        end
                        ewr[t+1]  = 1'b1;
                        edin[t+1] = w;
                        exp_words.push_back(w);
                    end
                    if (cnt == max_r) begin
                        done_t = t + 1;
                        break;
                    end
                end
            end
        end
        esamp[0] = prev_samp;
        eovf[0]  = prev_ovf;
        for (int t = 1; t <= n + 1; t++) begin
            foreach (accepts[i]) if (accepts[i] < t) esamp[t]++;
            eovf[t] = (ovf_t >= 0) && (t >= ovf_t);
            estop[t] = (done_t >= 0) && (t >= done_t) && (t <= n_go);
        end
        prev_samp = esamp[n+1];
        prev_ovf  = eovf[n+1];
    endtask

    task automatic drive_cycle(input int t);
        @(posedge clk);
        #1;
        cur_t      = t;
        run_active = 1'b1;
        go         = go_a[t];
        max_in     = 32'(max_r);
        dec_in     = 16'(dec_r);
        data_in    = data_a[t];
        or_in      = or_a[t];
        trig_in    = trig_a[t];
        full_in    = full_a[t];
    endtask

    task automatic do_run(input int n);
        build_expected(n);
        for (int t = 0; t <= n + 1; t++) drive_cycle(t);
        @(posedge clk);
        #1;
        run_active = 1'b0;
    endtask

    // Single compare process: outputs are meaningful in every run cycle.
    always @(negedge clk) begin
        if (run_active) begin
            chk("wr_en", cur_t, 64'(fifo_wr_en), 64'(ewr[cur_t]));
            if (ewr[cur_t]) chk("din", cur_t, 64'(fifo_din), 64'(edin[cur_t]));
            chk("stop", cur_t, 64'(capture_stop), 64'(estop[cur_t]));
            chk("samples", cur_t, 64'(samples), 64'(esamp[cur_t]));
            chk("overflow", cur_t, 64'(overflow), 64'(eovf[cur_t]));
        end
    end

    initial begin
        int n, n_go, sum;
        rst = 1'b1; go = 1'b0; max_in = '0; dec_in = '0; data_in = '0;
        or_in = 1'b0; trig_in = 1'b0; full_in = 1'b0;
        clear_stim();
        max_r = 0; dec_r = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_wr_en", 0, 64'(fifo_wr_en), 64'd0);
        chk("reset_din", 0, 64'(fifo_din), 64'd0);
        chk("reset_stop", 0, 64'(capture_stop), 64'd0);
        chk("reset_samples", 0, 64'(samples), 64'd0);
        chk("reset_overflow", 0, 64'(overflow), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: ramp 1..6, two full words
        ramp_stim(12, 6, 0);
        build_expected(12);
        chk("pin1_nwords", 0, 64'(exp_words.size()), 64'd2);
        if (exp_words.size() == 2) begin
            chk("pin1_w0", 0, 64'(exp_words[0]), 64'h0030_0801);
            chk("pin1_w1", 0, 64'(exp_words[1]), 64'h0060_1404);
        end
        prev_samp = 0; prev_ovf = 1'b0;
        do_run(12);

        // 2: max=7, trailing partial word
        ramp_stim(14, 7, 0);
        build_expected(14);
        chk("pin2_nwords", 0, 64'(exp_words.size()), FLUSH ? 64'd3 : 64'd2);
        if (FLUSH && exp_words.size() == 3)
            chk("pin2_w2", 0, 64'(exp_words[2]), 64'h0000_0007);
        prev_samp = 6; prev_ovf = 1'b0;
        do_run(14);

        // 3: decimate 2, data = capture-cycle index
        ramp_stim(14, 3, 2);
        for (int t = 1; t < 14; t++) data_a[t] = SW'(t - 1);
        build_expected(14);
        chk("pin3_nwords", 0, 64'(exp_words.size()), 64'd1);
        if (exp_words.size() == 1) chk("pin3_w0", 0, 64'(exp_words[0]), 64'h0060_0C00);
        prev_samp = 7; prev_ovf = 1'b0;
        do_run(14);

        // 4: FIFO full at second word completion
        ramp_stim(14, 9, 0);
        full_a[6] = 1'b1;
        build_expected(14);
        chk("pin4_nwords", 0, 64'(exp_words.size()), 64'd1);
        chk("pin4_ovf", 0, 64'(eovf[7]), 64'd1);
        prev_samp = 3; prev_ovf = 1'b0;
        do_run(14);

        // 5: OR on sample 2, trigger on sample 3
        ramp_stim(10, 3, 0);
        or_a[2] = 1'b1; trig_a[3] = 1'b1;
        build_expected(10);
        chk("pin5_nwords", 0, 64'(exp_words.size()), 64'd1);
        if (exp_words.size() == 1) chk("pin5_w0", 0, 64'(exp_words[0]), 64'hC030_0801);
        prev_samp = 6; prev_ovf = 1'b1;
        do_run(10);

        // 6a: abort after 4 samples
        ramp_stim(5, 10, 0);
        build_expected(12);
        sum = 0;
        for (int t = 0; t < 14; t++) sum += int'(estop[t]);
        chk("pin6_nwords", 0, 64'(exp_words.size()), 64'd1);
        chk("pin6_nostop", 0, 64'(sum), 64'd0);
        prev_samp = 3; prev_ovf = 1'b0;
        do_run(12);

        // 6b: max=0 goes straight to DONE
        ramp_stim(8, 0, 0);
        do_run(8);

        // Randomized runs
        for (int r = 0; r < 40; r++) begin
            clear_stim();
            n     = $urandom_range(4, 45);
            dec_r = $urandom_range(0, 3);
            max_r = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
            n_go  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : n;
            for (int t = 0; t < n_go; t++) go_a[t] = 1'b1;
            for (int t = 0; t < n; t++) begin
                data_a[t] = SW'($urandom_range(0, (1 << SW) - 1));
                or_a[t]   = ($urandom_range(0, 5) == 0);
                trig_a[t] = $urandom_range(0, 1) == 1;
                full_a[t] = ($urandom_range(0, 7) == 0);
            end
            do_run(n);
        end

        // Asynchronous reset in the middle of a capture
        ramp_stim(MAXC - 2, 20, 0);
        build_expected(MAXC - 2);
        for (int t = 0; t < 6; t++) drive_cycle(t);
        @(posedge clk);
        #1;
        run_active = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("areset_wr_en", 0, 64'(fifo_wr_en), 64'd0);
        chk("areset_din", 0, 64'(fifo_din), 64'd0);
        chk("areset_stop", 0, 64'(capture_stop), 64'd0);
        chk("areset_samples", 0, 64'(samples), 64'd0);
        chk("areset_overflow", 0, 64'(overflow), 64'd0);
        go = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        prev_samp = 0; prev_ovf = 1'b0;
        ramp_stim(10, 4, 1);
        do_run(10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
